// File: rtl/imem_loader_pkg.sv
// Shared state type and framing constants for the byte-stream program loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } loader_state_t;

    localparam int LEN_BYTES      = 2;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MEM_WIDTH  = 8;
    localparam int BYTES_PER_WORD = DEF_DATA_WIDTH / DEF_MEM_WIDTH;
    localparam int CSUM_W         = 8;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles a little-endian word from a byte stream; word_valid_o pulses the
// cycle after the last lane is filled and word_o holds until the next word.
module byte_packer
    import imem_loader_pkg::*;
#(
    parameter int  MEM_WIDTH = DEF_MEM_WIDTH,
    parameter int  BPW       = BYTES_PER_WORD,
    localparam int WORD_W    = BPW * MEM_WIDTH,
    localparam int IDX_W     = (BPW > 1) ? $clog2(BPW) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 byte_valid_i,
    input  logic [MEM_WIDTH-1:0] byte_i,
    output logic                 lane_last_o,
    output logic                 word_valid_o,
    output logic [WORD_W-1:0]    word_o
);

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;
    logic [WORD_W-1:0] shifted;

    // Shifting right from the top lane leaves the first byte in the low lane.
    assign shifted     = {byte_i, shift_q[WORD_W-1:MEM_WIDTH]};
    assign lane_last_o = (idx_q == IDX_W'(BPW - 1));

    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (clr_i) begin
            idx_d   = '0;
            shift_d = '0;
        end else if (byte_valid_i) begin
            shift_d = shifted;
            if (lane_last_o) begin
                idx_d   = '0;
                word_d  = shifted;
                valid_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word_valid_o = valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Framed program loader: length header, payload packed into words written from
// address 0, then a mod-256 checksum byte; holds busy while loading.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_WIDTH  = DEF_MEM_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [MEM_WIDTH-1:0]  in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-2:0] words_written,
    output loader_state_t         dbg_state_o
);

    localparam int          BPW        = DATA_WIDTH / MEM_WIDTH;
    localparam int          WORD_SHIFT = $clog2(BPW);
    localparam int          LEN_W      = LEN_BYTES * MEM_WIDTH;
    localparam logic [31:0] MAX_WORDS  = 32'(1) << (ADDR_WIDTH - 2);

    loader_state_t         state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [CSUM_W-1:0]     csum_q, csum_d;
    logic [ADDR_WIDTH-2:0] wcnt_q, wcnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  pack_clr, pack_valid, pack_last;
    logic                  word_valid;
    logic [DATA_WIDTH-1:0] word;
    logic [CSUM_W-1:0]     csum_sum;
    logic [LEN_W-1:0]      len_full;

    byte_packer #(
        .MEM_WIDTH (MEM_WIDTH),
        .BPW       (BPW)
    ) u_packer (
        .clk_i        (clk),
        .rst_ni       (rst),
        .clr_i        (pack_clr),
        .byte_valid_i (pack_valid),
        .byte_i       (in_data),
        .lane_last_o  (pack_last),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    assign csum_sum = csum_q + CSUM_W'(in_data);
    assign len_full = {in_data, len_q[MEM_WIDTH-1:0]};

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        csum_d     = csum_q;
        wcnt_d     = wcnt_q;
        addr_d     = addr_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        in_ready   = 1'b0;
        pack_clr   = 1'b0;
        pack_valid = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d  = S_LEN_LO;
                    len_d    = '0;
                    csum_d   = '0;
                    wcnt_d   = '0;
                    addr_d   = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    pack_clr = 1'b1;
                end
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    len_d   = {len_q[LEN_W-1:MEM_WIDTH], in_data};
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    len_d = len_full;
                    if (len_full == '0 || 32'(len_full) > MAX_WORDS) begin
                        state_d = S_ERR;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    pack_valid = 1'b1;
                    csum_d     = csum_sum;
                    // Address and count step on the edge that raises wr_en.
                    if (pack_last) begin
                        wcnt_d = wcnt_q + 1'b1;
                        addr_d = ADDR_WIDTH'(wcnt_q) << WORD_SHIFT;
                        if (32'(wcnt_q) + 32'd1 == 32'(len_q)) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    busy_d = 1'b0;
                    if (csum_sum == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            csum_q  <= '0;
            wcnt_q  <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            csum_q  <= csum_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign wr_en         = word_valid;
    assign wr_data       = word;
    assign wr_addr       = addr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign words_written = wcnt_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, checksum and length errors,
// stalls, mid-load reset and a full-memory image followed by a restart.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [MW-1:0] in_data = '0;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy, done, err;
    logic [AW-2:0] words_written;
    loader_state_t dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [AW-1:0] got_addr_q[$];
    logic [DW-1:0] got_data_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_data_q[$];
    logic [MW-1:0] pay_q[$];

    imem_loader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_WIDTH  (MW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .words_written (words_written),
        .dbg_state_o   (dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && wr_en) begin
            got_addr_q.push_back(wr_addr);
            got_data_q.push_back(wr_data);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [MW-1:0] b, input int max_gap);
        int guard;
        in_valid = 1'b0;
        repeat ($urandom_range(0, max_gap)) tick();
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $error("FAIL ready_timeout: in_ready=%0b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [MW-1:0] payload_sum();
        logic [MW-1:0] s = '0;
        foreach (pay_q[i]) s += pay_q[i];
        return s;
    endfunction

    task automatic build_expected();
        exp_addr_q.delete();
        exp_data_q.delete();
        for (int w = 0; w < pay_q.size() / 4; w++) begin
            exp_addr_q.push_back(AW'(w * 4));
            exp_data_q.push_back({pay_q[4*w+3], pay_q[4*w+2], pay_q[4*w+1], pay_q[4*w]});
        end
    endtask

    task automatic send_frame(input logic [15:0] len, input logic [MW-1:0] csum, input int max_gap);
        got_addr_q.delete();
        got_data_q.delete();
        send_byte(len[7:0], max_gap);
        send_byte(len[15:8], max_gap);
        foreach (pay_q[i]) send_byte(pay_q[i], max_gap);
        send_byte(csum, max_gap);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_wr_count"}, 64'(got_addr_q.size()), 64'(exp_addr_q.size()));
        for (int i = 0; i < exp_addr_q.size() && i < got_addr_q.size(); i++) begin
            check($sformatf("%s_addr[%0d]", tag, i), 64'(got_addr_q[i]), 64'(exp_addr_q[i]));
            check($sformatf("%s_data[%0d]", tag, i), 64'(got_data_q[i]), 64'(exp_data_q[i]));
        end
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic b,
                                input int ww);
        check({tag, "_done"}, 64'(done), 64'(d));
        check({tag, "_err"}, 64'(err), 64'(e));
        check({tag, "_busy"}, 64'(busy), 64'(b));
        check({tag, "_words"}, 64'(words_written), 64'(ww));
        check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    endtask

    task automatic set_basic_payload();
        pay_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        build_expected();
    endtask

    initial begin
        // Reset state
        #3 rst = 1'b0;
        repeat (2) tick();
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_wr_en", 64'(wr_en), 64'(0));
        check("rst_wr_addr", 64'(wr_addr), 64'(0));
        check("rst_wr_data", 64'(wr_data), 64'(0));
        check_status("rst", 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk) rst = 1'b1;
        tick();
        check("idle_state", 64'(dbg_state), 64'(S_IDLE));

        // Basic load; payload sums to 0xB6 so 0x4A closes the frame
        set_basic_payload();
        do_start();
        check("start_busy", 64'(busy), 64'(1));
        check("start_state", 64'(dbg_state), 64'(S_LEN_LO));
        check("start_in_ready", 64'(in_ready), 64'(1));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_while_busy", 64'(dbg_state), 64'(S_LEN_LO));
        send_frame(16'd2, 8'h4A, 0);
        check_writes("basic");
        check_status("basic", 1'b1, 1'b0, 1'b0, 2);
        check("basic_state", 64'(dbg_state), 64'(S_DONE));

        // Checksum error: 0xB6 + 0x6D = 0x23 mod 256
        do_start();
        check("restart_done_clr", 64'(done), 64'(0));
        check("restart_words_clr", 64'(words_written), 64'(0));
        send_frame(16'd2, 8'h6D, 0);
        check_writes("csum_bad");
        check_status("csum_bad", 1'b0, 1'b1, 1'b0, 2);

        // Zero length
        got_addr_q.delete();
        got_data_q.delete();
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check_status("len0", 1'b0, 1'b1, 1'b0, 0);
        check("len0_state", 64'(dbg_state), 64'(S_ERR));
        repeat (3) tick();
        check("len0_no_wr", 64'(got_addr_q.size()), 64'(0));

        // Length 0x0401 exceeds 1024 words
        do_start();
        check("len_big_err_clr", 64'(err), 64'(0));
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        check_status("len_big", 1'b0, 1'b1, 1'b0, 0);
        repeat (3) tick();
        check("len_big_no_wr", 64'(got_addr_q.size()), 64'(0));
        check("len_big_in_ready", 64'(in_ready), 64'(0));

        // 16-word frame with random gaps on in_valid
        pay_q.delete();
        for (int i = 0; i < 64; i++) pay_q.push_back(MW'(i * 37 + 5));
        build_expected();
        do_start();
        send_frame(16'd16, MW'(0) - payload_sum(), 3);
        check_writes("stall");
        check_status("stall", 1'b1, 1'b0, 1'b0, 16);

        // Reset during the sixth byte of the basic frame
        set_basic_payload();
        got_addr_q.delete();
        got_data_q.delete();
        do_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        in_valid = 1'b1;
        in_data  = 8'h00;
        #2 rst = 1'b0;
        #1;
        check("arst_in_ready", 64'(in_ready), 64'(0));
        check("arst_wr_en", 64'(wr_en), 64'(0));
        check("arst_wr_addr", 64'(wr_addr), 64'(0));
        check("arst_wr_data", 64'(wr_data), 64'(0));
        check_status("arst", 1'b0, 1'b0, 1'b0, 0);
        in_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk) rst = 1'b1;
        repeat (3) tick();
        check("arst_no_wr", 64'(got_addr_q.size()), 64'(0));
        check("arst_state", 64'(dbg_state), 64'(S_IDLE));
        do_start();
        send_frame(16'd2, 8'h4A, 0);
        check_writes("post_rst");
        check_status("post_rst", 1'b1, 1'b0, 1'b0, 2);

        // Full 1024-word image
        pay_q.delete();
        for (int i = 0; i < 4096; i++) pay_q.push_back(MW'(i * 3 + i / 256));
        build_expected();
        do_start();
        send_frame(16'd1024, MW'(0) - payload_sum(), 0);
        check_writes("full");
        if (got_addr_q.size() > 0) check("full_last_addr", 64'(got_addr_q[$]), 64'h0FFC);
        check_status("full", 1'b1, 1'b0, 1'b0, 1024);

        // Restart from DONE rewrites from address 0
        do_start();
        check("rs_done_clr", 64'(done), 64'(0));
        check("rs_words_clr", 64'(words_written), 64'(0));
        check("rs_busy", 64'(busy), 64'(1));
        set_basic_payload();
        send_frame(16'd2, 8'h4A, 0);
        check_writes("restart");
        check_status("restart", 1'b1, 1'b0, 1'b0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
